uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Byte buffer and dispatcher placed directly upstream of the UART transmitter input (tx_start / data_in / tx_busy). A producer pushes bytes at full clock rate into a circular FIFO. A small FSM pops one byte at a time and hands it to the transmitter with a one-cycle tx_start pulse, then waits for that frame to finish. The producer never has to track tx_busy itself.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2
ADDR_W, 4, log2(DEPTH); pointer width
BUSY_TIMEOUT, 4, cycles to wait for tx_busy to rise after tx_start before giving up

Ports:
clk  in  1  system clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
wr_en  in  1  push request; sampled every edge
wr_data  in  8  byte to push
full  out  1  count == DEPTH
empty  out  1  count == 0
count  out  ADDR_W+1  current occupancy, 0..DEPTH
overflow  out  1  one-cycle pulse when wr_en is seen while full
tx_busy  in  1  transmitter busy flag
tx_start  out  1  one-cycle start pulse to the transmitter
tx_data  out  8  byte presented to the transmitter; stable from tx_start until the next pop

Behaviour:
- Reset (clk edge with reset=1):
  - wr_ptr = rd_ptr = 0, count = 0, so empty=1 and full=0.
  - overflow=0, tx_start=0, tx_data=8'h00, FSM=IDLE, timeout counter=0.
  - Storage array is not cleared.
- Push:
  - Accepted when wr_en=1 and full=0. mem[wr_ptr] <= wr_data, wr_ptr increments modulo DEPTH.
  - When wr_en=1 and full=1 the byte is dropped and overflow=1 for exactly one cycle. A write is rejected even if a pop happens in the same cycle.
- Pop: happens only in IDLE, when empty=0 and tx_busy=0. tx_data <= mem[rd_ptr], rd_ptr increments modulo DEPTH, tx_start <= 1 for that one cycle.
- Count: push and pop in the same edge leaves count unchanged. Otherwise count goes +1 on push, -1 on pop. full, empty and count are all registered and consistent with each other.
- FSM:
  - IDLE: pop condition true -> WAIT_BUSY (tx_start high in the following cycle), timeout counter cleared.
  - WAIT_BUSY:
    - tx_busy=1 -> WAIT_DONE.
    - Otherwise the counter increments. When it reaches BUSY_TIMEOUT -> IDLE; the byte is treated as sent and not re-queued.
  - WAIT_DONE: tx_busy=0 -> IDLE.
  - tx_start is high only in the first cycle of WAIT_BUSY.
- Latency: push into an empty FIFO at edge N, with the FSM in IDLE and tx_busy=0:
  - count=1 after edge N.
  - Pop at edge N+1.
  - tx_start=1 between edges N+1 and N+2.
- Back-to-back frames: the next pop needs the FSM in IDLE with tx_busy=0, so there is at least one idle cycle between the fall of tx_busy and the next tx_start.
- Wrap-around: both pointers wrap from DEPTH-1 to 0. Byte order is strictly FIFO across the wrap.
- Reset mid-frame:
  - FIFO contents are discarded and the FSM goes to IDLE.
  - A frame already accepted by the transmitter completes there. No new tx_start is issued until tx_busy=0.
- The block never issues tx_start while tx_busy=1.

Test Plan:
1. Reset, then push 8'hA5 with tx_busy held 0 -> tx_start high exactly one cycle at edge N+1..N+2, tx_data=8'hA5, count goes 1 then 0, empty=1.
2. Push 8'h01..8'h05 back to back; a transmitter model raises tx_busy 1 cycle after tx_start and holds it 20 cycles -> five tx_start pulses carrying 01..05 in order, none while tx_busy=1, at least one cycle gap after each fall of tx_busy.
3. Hold tx_busy=1, push 17 bytes with DEPTH=16 -> full=1 and count=16 after the 16th; the 17th gives overflow=1 for one cycle and count stays 16. Release tx_busy -> the first 16 bytes are emitted in order, the 17th never appears.
4. Push 10, drain 10, push 10 more (pointers wrap past 15 -> 0) -> all 20 bytes emitted in push order.
5. tx_busy tied 0 with the transmitter never responding, push 8'h3C -> tx_start pulses once, the FSM returns to IDLE after 4 cycles in WAIT_BUSY, and the next queued byte dispatches.
6. Queue 4 bytes, assert reset for one edge during WAIT_DONE -> count=0, empty=1, tx_start=0. No further tx_start until new data is pushed and tx_busy=0.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Byte FIFO and dispatcher in front of a UART transmitter. The producer pushes
//   bytes at full clock rate. A small FSM pops one byte at a time, presents it
//   on tx_data with a one-cycle tx_start pulse, and then waits for the frame to
//   finish before it pops the next byte.
//
// Ports
//   clk       system clock, rising edge
//   reset     synchronous, active-high reset
//   wr_en     push request, sampled every edge
//   wr_data   byte to push
//   full      occupancy == DEPTH
//   empty     occupancy == 0
//   count     occupancy, 0..DEPTH
//   overflow  one-cycle pulse when a push is refused because the FIFO is full
//   tx_busy   transmitter busy flag
//   tx_start  one-cycle start pulse to the transmitter
//   tx_data   byte for the transmitter, held until the next pop
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data
);

  localparam int              TO_W       = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(BUSY_TIMEOUT);
  localparam logic [ADDR_W:0] COUNT_FULL = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,       // ready to pop when data is waiting and the transmitter is free
    WAIT_BUSY,  // start issued, waiting for the transmitter to acknowledge
    WAIT_DONE   // transmitter is sending, waiting for tx_busy to fall
  } state_t;

  state_t            state, state_nx;
  logic [TO_W-1:0]   to_cnt, to_cnt_nx;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count_nx;
  logic [7:0]        mem [DEPTH];
  logic              push, pop;

  // Flags are decoded from the registered count, so all three always agree.
  assign full  = (count == COUNT_FULL);
  assign empty = (count == '0);

  // A push is judged against the occupancy before the edge; a pop in the same
  // cycle does not make room for it.
  assign push = wr_en && !full;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement leaves a signal unassigned (no latches).
  always_comb begin
    state_nx  = state;
    to_cnt_nx = to_cnt;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty && !tx_busy) begin
          pop       = 1'b1;
          state_nx  = WAIT_BUSY;
          to_cnt_nx = '0;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nx = WAIT_DONE;
        end else begin
          // A transmitter that never answers must not stall the queue; the
          // byte is considered sent and is not re-queued.
          to_cnt_nx = to_cnt + TO_W'(1);
          if (to_cnt_nx == TO_LAST) state_nx = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    count_nx = count;
    unique case ({push, pop})
      2'b10:   count_nx = count + (ADDR_W + 1)'(1);
      2'b01:   count_nx = count - (ADDR_W + 1)'(1);
      default: count_nx = count;
    endcase
  end

  // NOTE: the storage array has no reset; its contents are meaningless until
  // written, and the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      to_cnt   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      state    <= state_nx;
      to_cnt   <= to_cnt_nx;
      count    <= count_nx;
      overflow <= wr_en && full;
      tx_start <= pop;
      // DEPTH is a power of two, so the pointers wrap by plain overflow.
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + ADDR_W'(1);
        tx_data <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Directed bench for uart_tx_fifo. A queue-based model predicts occupancy,
//   flags, overflow and every dispatch; a negedge process compares the DUT to
//   it each cycle. Literal checks and per-test byte logs pin the model.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int DEPTH        = 16;
  localparam int ADDR_W       = 4;
  localparam int BUSY_TIMEOUT = 4;

  logic            clk     = 1'b0;
  logic            reset   = 1'b1;
  logic            wr_en   = 1'b0;
  logic [7:0]      wr_data = 8'h00;
  logic            full, empty, overflow, tx_busy, tx_start;
  logic [ADDR_W:0] count;
  logic [7:0]      tx_data;

  logic busy_forced = 1'b0;
  logic busy_xmit   = 1'b0;
  bit   xmit_on     = 1'b0;
  int   frame_len   = 20;

  assign tx_busy = busy_forced | busy_xmit;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Queue of bytes waiting, plus a "dispatcher engaged" notion: after a start,
  // the dispatcher is busy until the transmitter either finishes a frame it
  // acknowledged, or fails to acknowledge within BUSY_TIMEOUT cycles.
  byte unsigned mq[$];
  bit           m_valid     = 1'b0;
  bit           m_engaged   = 1'b0;
  bit           m_seen_busy = 1'b0;
  int           m_wait      = 0;
  bit           m_disp, m_acc;
  logic         exp_start = 1'b0;
  logic         exp_over  = 1'b0;
  logic [7:0]   exp_data  = 8'h00;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_valid   = 1'b1;
      m_engaged = 1'b0;
      exp_start = 1'b0;
      exp_over  = 1'b0;
      exp_data  = 8'h00;
    end else begin
      m_disp    = !m_engaged && (mq.size() != 0) && !tx_busy;
      m_acc     = wr_en && (mq.size() < DEPTH);
      exp_over  = wr_en && (mq.size() == DEPTH);
      exp_start = m_disp;
      if (m_disp) begin
        exp_data    = mq.pop_front();
        m_engaged   = 1'b1;
        m_seen_busy = 1'b0;
        m_wait      = 0;
      end else if (m_engaged) begin
        if (!m_seen_busy) begin
          if (tx_busy) m_seen_busy = 1'b1;
          else begin
            m_wait++;
            if (m_wait == BUSY_TIMEOUT) m_engaged = 1'b0;
          end
        end else if (!tx_busy) begin
          m_engaged = 1'b0;
        end
      end
      if (m_acc) mq.push_back(wr_data);
    end
  end

  // ---------------- per-cycle compare + dispatch log ----------------
  byte unsigned sent[$];
  byte unsigned exp_log[$];

  always @(negedge clk) begin
    if (m_valid) begin
      check("count",    32'(count),    32'(mq.size()));
      check("full",     32'(full),     32'(mq.size() == DEPTH));
      check("empty",    32'(empty),    32'(mq.size() == 0));
      check("overflow", 32'(overflow), 32'(exp_over));
      check("tx_start", 32'(tx_start), 32'(exp_start));
      check("tx_data",  32'(tx_data),  32'(exp_data));
      if (tx_start === 1'b1) sent.push_back(tx_data);
    end
  end

  // Transmitter stand-in: raises busy one cycle after tx_start, holds it
  // frame_len cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (xmit_on && tx_start === 1'b1) begin
        @(posedge clk); #2 busy_xmit = 1'b1;
        repeat (frame_len) @(posedge clk);
        #2 busy_xmit = 1'b0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input int budget);
    int i = 0;
    while (!(empty === 1'b1 && tx_busy === 1'b0 && !m_engaged) && i < budget) begin
      step();
      i++;
    end
    check("drain_in_budget", 32'(i < budget), 32'd1);
    repeat (3) step();
  endtask

  task automatic expect_range(input int first, input int n);
    for (int i = 0; i < n; i++) exp_log.push_back(8'(first + i));
  endtask

  task automatic check_log(input string name);
    int n;
    check($sformatf("%s_len", name), 32'(sent.size()), 32'(exp_log.size()));
    n = (sent.size() < exp_log.size()) ? sent.size() : exp_log.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s[%0d]", name, i), 32'(sent[i]), 32'(exp_log[i]));
    sent.delete();
    exp_log.delete();
  endtask

  task automatic push_burst(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(first + i);
      step();
    end
    wr_en = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int i;
    repeat (2) step();
    check("reset_count", 32'(count), 32'd0);
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_full",  32'(full),  32'd0);
    check("reset_data",  32'(tx_data), 32'h00);
    reset = 1'b0;

    // 1: single byte, transmitter silent
    wr_en = 1'b1; wr_data = 8'hA5; step();
    check("t1_count_after_push", 32'(count), 32'd1);
    check("t1_no_start_yet", 32'(tx_start), 32'd0);
    wr_en = 1'b0; step();
    check("t1_start", 32'(tx_start), 32'd1);
    check("t1_data", 32'(tx_data), 32'hA5);
    check("t1_count_after_pop", 32'(count), 32'd0);
    check("t1_empty", 32'(empty), 32'd1);
    step();
    check("t1_start_one_cycle", 32'(tx_start), 32'd0);
    wait_drain(100);
    exp_log.push_back(8'hA5);
    check_log("t1_log");

    // 2: five bytes through a responding transmitter
    xmit_on = 1'b1; frame_len = 20;
    push_burst(8'h01, 5);
    wait_drain(1000);
    expect_range(8'h01, 5);
    check_log("t2_log");

    // 3: fill while busy, overflow, then drain
    busy_forced = 1'b1; step();
    push_burst(8'h40, 16);
    check("t3_count_full", 32'(count), 32'd16);
    check("t3_full", 32'(full), 32'd1);
    wr_en = 1'b1; wr_data = 8'h50; step();
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_count_held", 32'(count), 32'd16);
    wr_en = 1'b0; step();
    check("t3_overflow_pulse", 32'(overflow), 32'd0);
    frame_len = 4; busy_forced = 1'b0;
    wait_drain(2000);
    expect_range(8'h40, 16);
    check_log("t3_log");

    // 4: wrap-around across two batches
    push_burst(8'h60, 10);
    wait_drain(2000);
    push_burst(8'h70, 10);
    wait_drain(2000);
    expect_range(8'h60, 10);
    expect_range(8'h70, 10);
    check_log("t4_log");

    // 5: transmitter never answers; timeout releases the dispatcher
    xmit_on = 1'b0;
    push_burst(8'h3C, 2);
    wait_drain(200);
    expect_range(8'h3C, 2);
    check_log("t5_log");

    // 6: reset while a frame is in flight
    xmit_on = 1'b1; frame_len = 20;
    push_burst(8'h90, 4);
    i = 0;
    while (tx_busy !== 1'b1 && i < 50) begin step(); i++; end
    check("t6_busy_seen", 32'(i < 50), 32'd1);
    repeat (2) step();
    reset = 1'b1; step();
    reset = 1'b0;
    check("t6_count", 32'(count), 32'd0);
    check("t6_empty", 32'(empty), 32'd1);
    check("t6_no_start", 32'(tx_start), 32'd0);
    repeat (8) step();
    push_burst(8'h94, 1);
    wait_drain(500);
    exp_log.push_back(8'h90);
    exp_log.push_back(8'h94);
    check_log("t6_log");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
